// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: widths, funct3 width codes,
// FSM states and the request-side decode helpers.
package load_store_unit_pkg;

  localparam int MEMORY_ADDR_W   = 32;
  localparam int REGISTER_DATA_W = 32;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_width_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Legal width code and naturally aligned; unsigned widths exist only for loads.
  function automatic logic access_ok(input logic       is_store,
                                     input logic [2:0] funct3,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (lsu_width_e'(funct3))
      LSU_B:   ok = 1'b1;
      LSU_H:   ok = !off[0];
      LSU_W:   ok = (off == 2'b00);
      LSU_BU:  ok = !is_store;
      LSU_HU:  ok = !is_store && !off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] funct3,
                                              input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (lsu_width_e'(funct3))
      LSU_B, LSU_BU: be = 4'b0001 << off;
      LSU_H, LSU_HU: be = 4'b0011 << off;
      LSU_W:         be = 4'b1111;
      default:       be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [REGISTER_DATA_W-1:0] replicate_wdata(
      input logic [2:0]                 funct3,
      input logic [REGISTER_DATA_W-1:0] wdata);
    logic [REGISTER_DATA_W-1:0] d;
    case (funct3[1:0])
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Load formatter: picks the addressed byte/halfword out of the memory word
// and sign- or zero-extends it to register width.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [REGISTER_DATA_W-1:0] mem_rdata,
  input  logic [1:0]                 addr_lo,
  input  logic [2:0]                 funct3,
  output logic [REGISTER_DATA_W-1:0] rdata_next
);

  logic [REGISTER_DATA_W-1:0] w_shifted;
  logic [7:0]                 w_byte;
  logic [15:0]                w_half;

  assign w_shifted = mem_rdata >> {addr_lo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    // NOTE: assign a default before the case so no path leaves rdata_next unassigned (no latch).
    rdata_next = '0;
    case (lsu_width_e'(funct3))
      LSU_B:   rdata_next = {{24{w_byte[7]}}, w_byte};
      LSU_H:   rdata_next = {{16{w_half[15]}}, w_half};
      LSU_W:   rdata_next = mem_rdata;
      LSU_BU:  rdata_next = {24'd0, w_byte};
      LSU_HU:  rdata_next = {16'd0, w_half};
      default: rdata_next = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one req/ack transaction per accepted start,
// with misalignment detection, ack timeout and formatted load writeback.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W  = MEMORY_ADDR_W,
  parameter int DATA_W  = REGISTER_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              misaligned,
  output logic              bus_err,
  load_store_unit_if.master mem
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  lsu_state_e        r_state;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_rdata;
  logic              r_misaligned;
  logic              r_bus_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [7:0]        r_cnt;

  logic [DATA_W-1:0] w_rdata_next;

  load_align u_load_align (
    .mem_rdata  (mem.mem_rdata),
    .addr_lo    (r_off),
    .funct3     (r_funct3),
    .rdata_next (w_rdata_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
      r_is_store   <= 1'b0;
      r_funct3     <= '0;
      r_off        <= '0;
      r_cnt        <= '0;
    end else begin
      // NOTE: every register here uses <= so all updates see the pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_is_store   <= is_store;
            r_funct3     <= funct3;
            r_off        <= addr[1:0];
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
            r_busy       <= 1'b1;
            if (!access_ok(is_store, funct3, addr[1:0])) begin
              // Rejected accesses never touch the bus and report straight away.
              r_misaligned <= 1'b1;
              r_done       <= 1'b1;
              r_state      <= ST_RESP;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= is_store;
              r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              r_mem_be    <= byte_enables(funct3, addr[1:0]);
              r_mem_wdata <= replicate_wdata(funct3, wdata);
              r_cnt       <= '0;
              r_state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // Ack is checked before the timeout so a last-cycle ack still completes.
          if (mem.mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (!r_is_store) r_rdata <= w_rdata_next;
            r_done    <= 1'b1;
            r_state   <= ST_RESP;
          end else if (r_cnt == LP_TIMEOUT) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_bus_err <= 1'b1;
            r_rdata   <= '0;
            r_done    <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign rdata         = r_rdata;
  assign misaligned    = r_misaligned;
  assign bus_err       = r_bus_err;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_be    = r_mem_be;
  assign mem.mem_wdata = r_mem_wdata;

endmodule
